pll_reset_sequencer: RTL

- Sequences the clocking PLL from power-up to a usable system: drives PLL reset, qualifies lock, and releases the two downstream domain resets in order.
- Retries PLL reset on lock timeout; declares a fault after too many retries.
- Re-runs the whole sequence on loss of lock or a software restart request.
- Runs on the free-running PLL reference clock. Its reset outputs feed per-domain reset synchronizers in the clk_out1 and clk_out2 domains.

---
 rtl/pll_reset_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: drives PLL reset, qualifies lock and
// releases the clk_out1 then clk_out2 domain resets in order.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES     = 4,
  parameter int unsigned LOCK_TIMEOUT       = 1000,
  parameter int unsigned LOCK_STABLE_CYCLES = 16,
  parameter int unsigned RELEASE_GAP        = 8,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int unsigned CNT_W              = 16
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       locked,
  input  logic       restart_req,
  output logic       pll_resetn,
  output logic       rst_out1,
  output logic       rst_out2,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(RELEASE_GAP - 1);
  localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);

  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       retry_nxt;
  logic             sync1;
  logic             locked_s;
  logic             pll_resetn_d;
  logic             rst_out1_d;
  logic             rst_out2_d;

  // locked is asynchronous to clk_in
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= locked;
      locked_s <= sync1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cur         <= RESET_PLL;
      cnt         <= '0;
      retry_count <= 4'd0;
      pll_resetn  <= 1'b0;
      rst_out1    <= 1'b1;
      rst_out2    <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      cur         <= nxt;
      cnt         <= cnt_nxt;
      retry_count <= retry_nxt;
      pll_resetn  <= pll_resetn_d;
      rst_out1    <= rst_out1_d;
      rst_out2    <= rst_out2_d;
      ready       <= (nxt == RUN);
      fault       <= (nxt == FAULT);
    end
  end

  always_comb begin
    nxt       = cur;
    cnt_nxt   = cnt;
    retry_nxt = retry_count;
    if (restart_req) begin
      nxt       = RESET_PLL;
      cnt_nxt   = '0;
      retry_nxt = 4'd0;
    end else begin
      unique case (cur)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            nxt     = WAIT_LOCK;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // lock wins over a coincident timeout
          if (locked_s) begin
            nxt     = STABLE;
            cnt_nxt = '0;
          end else if (cnt == TO_LAST) begin
            cnt_nxt = '0;
            if (retry_count >= MAX_R) begin
              nxt = FAULT;
            end else begin
              nxt       = RESET_PLL;
              retry_nxt = retry_count + 4'd1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            nxt     = WAIT_LOCK;
            cnt_nxt = '0;
          end else if (cnt == STB_LAST) begin
            nxt     = RELEASE;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!locked_s) begin
            nxt     = RESET_PLL;
            cnt_nxt = '0;
          end else if (cnt == GAP_LAST) begin
            nxt       = RUN;
            cnt_nxt   = '0;
            retry_nxt = 4'd0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            nxt     = RESET_PLL;
            cnt_nxt = '0;
          end
        end
        FAULT: begin
          nxt = FAULT;
        end
        default: begin
          nxt     = RESET_PLL;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // outputs are decoded from the next state so they register with it
  always_comb begin
    pll_resetn_d = 1'b1;
    rst_out1_d   = 1'b1;
    rst_out2_d   = 1'b1;
    unique case (1'b1)
      (nxt == RESET_PLL),
      (nxt == FAULT): begin
        pll_resetn_d = 1'b0;
      end
      (nxt == RELEASE): begin
        rst_out1_d = 1'b0;
      end
      (nxt == RUN): begin
        rst_out1_d = 1'b0;
        rst_out2_d = 1'b0;
      end
      default: begin
        pll_resetn_d = 1'b1;
      end
    endcase
  end

  assign state = cur;

endmodule
